// File: rtl/microcpu_mem_pkg.sv
// Shared constants for the CPU data-memory responder and its MMIO window.
package microcpu_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_FF00;

    // MMIO word offsets within the window
    localparam logic [7:0] MMIO_TXDATA = 8'h00;
    localparam logic [7:0] MMIO_STATUS = 8'h01;
    localparam logic [7:0] MMIO_CYCLES = 8'h02;

    // STATUS register bit positions
    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_RANGE_ERR = 3;
    localparam int unsigned ST_COUNT_LSB = 4;

    // Assemble the STATUS read word from its fields
    function automatic logic [WORD_W-1:0] pack_status(
        input logic [3:0] count,
        input logic       range_err,
        input logic       ovf,
        input logic       full,
        input logic       empty
    );
        logic [WORD_W-1:0] w;
        w                          = '0;
        w[ST_EMPTY]                = empty;
        w[ST_FULL]                 = full;
        w[ST_OVF]                  = ovf;
        w[ST_RANGE_ERR]            = range_err;
        w[ST_COUNT_LSB +: 4]       = count;
        return w;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO feeding the MMIO output sink; a push into a full FIFO is only
// accepted when a pop frees a slot in the same cycle.
module byte_fifo
    import microcpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [BYTE_W-1:0] head_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; stale entries are masked by the empty gate on head_o
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target: word RAM, MMIO byte FIFO, cycle counter and sticky
// error flags. Loads return combinationally; stores commit at the edge.
module data_mem_responder
    import microcpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [WORD_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] data_mem_in,
    output logic [WORD_W-1:0] data_mem_out,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int unsigned RAM_WORDS = 1 << ADDR_W;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [WORD_W:0] RAM_LIMIT = (WORD_W+1)'(1) << ADDR_W;

    logic [WORD_W-1:0] ram_q [RAM_WORDS];
    logic [WORD_W-1:0] cycles_q, cycles_d;
    logic              ovf_q, ovf_d;
    logic              range_err_q, range_err_d;

    logic              is_mmio, is_ram, is_bad;
    logic [7:0]        offset;
    logic              tx_push, fifo_pop;
    logic              fifo_empty, fifo_full;
    logic [CNT_W-1:0]  fifo_count;
    logic [BYTE_W-1:0] fifo_head;

    // Address decode; the MMIO window takes priority over RAM
    always_comb begin
        offset  = ram_addr[7:0];
        is_mmio = (ram_addr >= MMIO_BASE);
        is_ram  = !is_mmio && ({1'b0, ram_addr} < RAM_LIMIT);
        is_bad  = !is_mmio && !is_ram;
        tx_push = mem_wr && is_mmio && (offset == MMIO_TXDATA);
    end

    assign fifo_pop  = out_valid && out_ready;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (tx_push),
        .pop_i   (fifo_pop),
        .data_i  (data_mem_in[BYTE_W-1:0]),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Combinational read mux returning pre-edge state
    always_comb begin
        data_mem_out = '0;
        if (mem_rd) begin
            if (is_mmio) begin
                case (offset)
                    MMIO_STATUS: data_mem_out = pack_status(4'(fifo_count), range_err_q,
                                                            ovf_q, fifo_full, fifo_empty);
                    MMIO_CYCLES: data_mem_out = cycles_q;
                    default:     data_mem_out = '0;
                endcase
            end else if (is_ram) begin
                data_mem_out = ram_q[ram_addr[ADDR_W-1:0]];
            end
        end
    end

    // Counter and sticky flags next-state; a set wins over a clear
    always_comb begin
        cycles_d    = cycles_q + 32'd1;
        ovf_d       = ovf_q;
        range_err_d = range_err_q;
        if (mem_wr && is_mmio && (offset == MMIO_CYCLES)) cycles_d = data_mem_in;
        if (mem_wr && is_mmio && (offset == MMIO_STATUS)) begin
            if (data_mem_in[ST_OVF])       ovf_d       = 1'b0;
            if (data_mem_in[ST_RANGE_ERR]) range_err_d = 1'b0;
        end
        if (tx_push && fifo_full && !fifo_pop) ovf_d       = 1'b1;
        if ((mem_rd || mem_wr) && is_bad)      range_err_d = 1'b1;
    end

    // Counter and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles_q    <= '0;
            ovf_q       <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            cycles_q    <= cycles_d;
            ovf_q       <= ovf_d;
            range_err_q <= range_err_d;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_wr && is_ram) ram_q[ram_addr[ADDR_W-1:0]] <= data_mem_in;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Target side of the CPU data-memory interface: services `mem_rd`/`mem_wr` requests at `ram_addr` with a word RAM plus a small MMIO window. The MMIO window holds a byte output FIFO drained by a valid/ready sink, a free-running cycle counter and sticky error flags. It sits beside the CPU core and returns `data_mem_out` combinationally, because the core completes loads in one cycle.

## Interface
Parameters:
- `ADDR_W`, 10: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- `MMIO_BASE`, 32'hFFFF_FF00: first word address of the MMIO window, which spans 256 words.
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `mem_rd` in 1: read strobe from the core.
- `mem_wr` in 1: write strobe from the core.
- `ram_addr` in 32: word address.
- `data_mem_in` in 32: write data.
- `data_mem_out` out 32: read data, combinational.
- `out_valid` out 1: FIFO head is valid.
- `out_data` out 8: FIFO head byte.
- `out_ready` in 1: sink accepts the head this cycle.

## Operation
- Decode:
  - MMIO when `ram_addr >= MMIO_BASE`; offset is `ram_addr[7:0]`.
  - RAM when `ram_addr < 2^ADDR_W`.
  - Any other address is out-of-range.
- RAM:
  - Asynchronous read of word `ram_addr[ADDR_W-1:0]`.
  - Synchronous write when `mem_wr`.
  - Contents are not cleared by reset.
- Out-of-range access:
  - Read returns 0; write is ignored.
  - Either access sets sticky `RANGE_ERR`.
- MMIO offset 0x00 TXDATA:
  - Write pushes `data_mem_in[7:0]`.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and sticky `OVF` is set.
  - Read returns 0.
- MMIO offset 0x01 STATUS:
  - Read returns `{24'b0, count[3:0], RANGE_ERR, OVF, full, empty}`.
  - Write is write-1-to-clear: `data_mem_in[2]` clears `OVF`, `data_mem_in[3]` clears `RANGE_ERR`; other bits are ignored.
  - Set beats clear when both occur in the same cycle.
- MMIO offset 0x02 CYCLES:
  - 32-bit counter, increments every cycle and wraps from FFFF_FFFF to 0.
  - A write loads `data_mem_in`; the load beats the increment.
  - Read returns the current (pre-edge) value.
- Other MMIO offsets: read 0, write ignored, no flag set.
- `data_mem_out` is 0 whenever `mem_rd` is low.
- `mem_rd` and `mem_wr` together: the write commits at the edge; the read returns the pre-write value.
- FIFO:
  - `out_valid = !empty`; `out_data` is the head byte, and is 0 when empty.
  - Pop occurs on `out_valid && out_ready`.
  - Push and pop in the same cycle when full: both occur, count is unchanged, no `OVF`.
  - Push and pop in the same cycle when empty: the push is stored, the pop is a no-op.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - `count` ranges 0..`FIFO_DEPTH`.

## Timing
- Read latency is 0 cycles (combinational from `ram_addr`/`mem_rd`); write latency is 1 edge.
- A pushed byte appears on `out_valid`/`out_data` the cycle after the push edge.
- `out_data` is held stable while `out_valid && !out_ready`.
- Reset assertion takes effect immediately, mid-transfer included. It forces:
  - FIFO empty, so `out_valid` = 0 and `out_data` = 0.
  - `count` = 0, `OVF` = 0, `RANGE_ERR` = 0, CYCLES = 0.
- Reset does not touch RAM contents. Any byte being offered at reset assertion is discarded.
- First CYCLES increment occurs on the first rising edge after reset deasserts.

## Structure
- Shared package `microcpu_mem_pkg` holds:
  - MMIO offset constants `MMIO_TXDATA`, `MMIO_STATUS`, `MMIO_CYCLES`.
  - STATUS bit indices `ST_EMPTY`, `ST_FULL`, `ST_OVF`, `ST_RANGE_ERR`, `ST_COUNT_LSB`.
  - Default `MMIO_BASE`.
- One sub-module, `byte_fifo`:
  - Parameterised by depth.
  - Ports: push/pop/data in, head/empty/full/count out, same clock and reset.
- Decode, RAM, counter and flags live in the top.

## Test plan
- Reset release, then write 0xDEADBEEF to addr 5 and read addr 5 → `data_mem_out` = 0xDEADBEEF the same cycle as the read; reading addr 6 in the first cycle after reset (RAM unwritten) returns X-free data only after it has been written.
- Write 0x41, 0x42, 0x43 to TXDATA with `out_ready` = 0 → STATUS reads count = 3, empty = 0. Raise `out_ready` → 0x41, 0x42, 0x43 appear in order, then `out_valid` = 0.
- Push 9 bytes with `out_ready` = 0 → STATUS = full, count = 8, `OVF` = 1, 9th byte absent. Write STATUS 0x4 → `OVF` = 0. A push while full with `out_ready` = 1 → accepted, `OVF` stays 0.
- Write CYCLES = 0xFFFF_FFFE, read two cycles later → reads 0x0000_0000 (wrapped). A write in the same cycle as the increment → loaded value wins.
- Read `ram_addr` = 0x0000_8000 → returns 0 and STATUS `RANGE_ERR` = 1. Write STATUS 0x8 → cleared.
- Assert `reset` low asynchronously with 3 bytes queued → `out_valid` drops before the next edge, count = 0, CYCLES = 0.
